// File: rtl/e15_obs.sv
// ============================================================================
// Module   : e15_obs
// Brief    : Passive observer that decodes e15 output vectors, tracks the set
//            of reachable controller states and flags impossible sequences.
// Revision : 1.0
// ============================================================================
`default_nettype none

module e15_obs #(
  parameter int CNT_W  = 8,
  parameter int STEP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample,
  input  logic [19:0]       y,
  output logic [17:0]       cand,
  output logic [4:0]        cur_state,
  output logic              locked,
  output logic              viol,
  output logic [1:0]        viol_code,
  output logic [CNT_W-1:0]  viol_cnt,
  output logic [STEP_W-1:0] step_cnt
);

  localparam logic [17:0] c_HOLD  = 18'h15368;  // s4 s6 s7 s9 s10 s13 s15 s17
  localparam logic [17:0] c_TO_S1 = 18'h13CAA;  // s2 s4 s6 s8 s11 s12 s13 s14 s17
  localparam logic [1:0]  c_CODE_BAD  = 2'd1;
  localparam logic [1:0]  c_CODE_SUCC = 2'd2;

  function automatic logic [17:0] sbit(input int k);
    return 18'd1 << (k - 1);
  endfunction

  function automatic logic [17:0] succ_of(input int k);
    logic [17:0] m;
    m = '0;
    case (k)
      1:  m = 18'h007FE;
      2:  m = sbit(13);
      3:  m = sbit(11) | sbit(12) | sbit(13) | sbit(14);
      4:  m = sbit(9)  | sbit(11) | sbit(15) | sbit(16);
      5:  m = sbit(11) | sbit(12);
      6:  m = sbit(4)  | sbit(14);
      7:  m = sbit(17) | sbit(18);
      8:  m = sbit(10) | sbit(16);
      9:  m = sbit(5)  | sbit(11) | sbit(12) | sbit(17) | sbit(18);
      10: m = sbit(2)  | sbit(16);
      11: m = sbit(3)  | sbit(4)  | sbit(6)  | sbit(7)  | sbit(10);
      12: m = sbit(3)  | sbit(4)  | sbit(6)  | sbit(7)  | sbit(10) | sbit(17);
      13: m = sbit(8);
      14: m = sbit(2)  | sbit(13);
      15: m = sbit(14);
      16: m = sbit(2)  | sbit(11) | sbit(12);
      17: m = sbit(2)  | sbit(12) | sbit(13) | sbit(17);
      18: m = sbit(2)  | sbit(12) | sbit(17);
      default: m = '0;
    endcase
    return m;
  endfunction

  logic [17:0]       r_cand;
  logic [4:0]        r_cur_state;
  logic              r_locked;
  logic              r_viol;
  logic [1:0]        r_viol_code;
  logic [CNT_W-1:0]  r_viol_cnt;
  logic [STEP_W-1:0] r_step_cnt;

  logic [4:0]  w_dec;
  logic        w_bad;
  logic [17:0] w_reach;
  logic [17:0] w_next;
  logic        w_viol;
  logic [1:0]  w_code;
  logic [4:0]  w_enc;

  // Exact-match decode; 0 means silent (or bad when w_bad is set).
  always_comb begin
    w_dec = 5'd0;
    w_bad = 1'b0;
    case (y)
      20'h00000: w_dec = 5'd0;
      20'h08000: w_dec = 5'd2;
      20'h40000: w_dec = 5'd3;
      20'h00181: w_dec = 5'd4;
      20'h00007: w_dec = 5'd5;
      20'h00803: w_dec = 5'd6;
      20'h00A02: w_dec = 5'd7;
      20'h20000: w_dec = 5'd8;
      20'h00E00: w_dec = 5'd9;
      20'h04140: w_dec = 5'd10;
      20'h00010: w_dec = 5'd11;
      20'h00008: w_dec = 5'd12;
      20'h10180: w_dec = 5'd13;
      20'h00020: w_dec = 5'd14;
      20'h00C01: w_dec = 5'd15;
      20'h80000: w_dec = 5'd16;
      20'h06101: w_dec = 5'd17;
      20'h01000: w_dec = 5'd18;
      default:   w_bad = 1'b1;
    endcase
  end

  always_comb begin
    w_reach = '0;
    for (int k = 0; k < 18; k++) begin
      if (r_cand[k]) w_reach = w_reach | succ_of(k + 1);
    end
  end

  always_comb begin
    w_next = r_cand;
    w_viol = 1'b0;
    w_code = r_viol_code;
    if (w_bad) begin
      w_next = '1;
      w_viol = 1'b1;
      w_code = c_CODE_BAD;
    end else if (w_dec != 5'd0) begin
      // An unexpected announcement still resynchronises to the decoded state.
      w_next = sbit(int'(w_dec));
      if ((w_reach & w_next) == 18'd0) begin
        w_viol = 1'b1;
        w_code = c_CODE_SUCC;
      end
    end else begin
      w_next = (r_cand & c_HOLD) | (((r_cand & c_TO_S1) != 18'd0) ? 18'd1 : 18'd0);
      if (w_next == 18'd0) begin
        w_next = 18'd1;
        w_viol = 1'b1;
        w_code = c_CODE_SUCC;
      end
    end
  end

  always_comb begin
    w_enc = 5'd0;
    for (int k = 0; k < 18; k++) begin
      if (w_next == (18'd1 << k)) w_enc = 5'(k + 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cand      <= 18'd1;
      r_cur_state <= 5'd1;
      r_locked    <= 1'b1;
      r_viol      <= 1'b0;
      r_viol_code <= 2'd0;
      r_viol_cnt  <= '0;
      r_step_cnt  <= '0;
    end else if (sample) begin
      r_cand      <= w_next;
      r_cur_state <= w_enc;
      r_locked    <= (w_enc != 5'd0);
      r_viol_code <= w_code;
      r_step_cnt  <= r_step_cnt + 1'b1;
      if (w_viol) begin
        r_viol <= 1'b1;
        if (r_viol_cnt != {CNT_W{1'b1}}) r_viol_cnt <= r_viol_cnt + 1'b1;
      end
    end
  end

  assign cand      = r_cand;
  assign cur_state = r_cur_state;
  assign locked    = r_locked;
  assign viol      = r_viol;
  assign viol_code = r_viol_code;
  assign viol_cnt  = r_viol_cnt;
  assign step_cnt  = r_step_cnt;

endmodule

`default_nettype wire

// File: tb/tb_e15_obs.sv
// ============================================================================
// Module   : tb_e15_obs
// Brief    : Directed self-checking bench for the e15 output observer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_e15_obs;

  localparam logic [19:0] c_Y16   = 20'h08000;  // s2
  localparam logic [19:0] c_Y13S  = 20'h10180;  // y8y9y17 -> s13
  localparam logic [19:0] c_Y18   = 20'h20000;  // s8
  localparam logic [19:0] c_S9    = 20'h00E00;  // y10y11y12
  localparam logic [19:0] c_S17   = 20'h06101;  // y1y9y14y15
  localparam logic [19:0] c_S10   = 20'h04140;  // y7y9y15
  localparam logic [19:0] c_S4    = 20'h00181;  // y1y8y9
  localparam logic [19:0] c_S5    = 20'h00007;  // y1y2y3
  localparam logic [19:0] c_Y5    = 20'h00010;  // s11
  localparam logic [19:0] c_Y4    = 20'h00008;  // s12
  localparam logic [19:0] c_Y1    = 20'h00001;  // bad pattern
  localparam logic [19:0] c_SIL   = 20'h00000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample = 1'b0;
  logic [19:0] y = '0;

  logic [17:0] cand, cand2;
  logic [4:0]  cur_state, cur_state2;
  logic        locked, locked2;
  logic        viol, viol2;
  logic [1:0]  viol_code, viol_code2;
  logic [7:0]  viol_cnt;
  logic [1:0]  viol_cnt2;
  logic [15:0] step_cnt, step_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  e15_obs #(.CNT_W(8), .STEP_W(16)) dut (
    .clk(clk), .rst(rst), .sample(sample), .y(y),
    .cand(cand), .cur_state(cur_state), .locked(locked), .viol(viol),
    .viol_code(viol_code), .viol_cnt(viol_cnt), .step_cnt(step_cnt)
  );

  e15_obs #(.CNT_W(2), .STEP_W(16)) dut2 (
    .clk(clk), .rst(rst), .sample(sample), .y(y),
    .cand(cand2), .cur_state(cur_state2), .locked(locked2), .viol(viol2),
    .viol_code(viol_code2), .viol_cnt(viol_cnt2), .step_cnt(step_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic smp(input logic [19:0] v);
    @(negedge clk);
    sample = 1'b1;
    y      = v;
    @(posedge clk);
    #1;
    sample = 1'b0;
    y      = '0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cand"},  32'(cand), 32'h1);
    chk({tag, "_cur"},   32'(cur_state), 32'd1);
    chk({tag, "_lock"},  32'(locked), 32'd1);
    chk({tag, "_viol"},  32'(viol), 32'd0);
    chk({tag, "_code"},  32'(viol_code), 32'd0);
    chk({tag, "_vcnt"},  32'(viol_cnt), 32'd0);
    chk({tag, "_step"},  32'(step_cnt), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_reset("rst");
    @(negedge clk);
    rst = 1'b0;

    // sample=0 must hold everything
    @(negedge clk);
    y = c_Y16;
    @(posedge clk);
    #1;
    chk("hold_cur", 32'(cur_state), 32'd1);
    chk("hold_step", 32'(step_cnt), 32'd0);
    y = '0;

    // Legal walk s1 -> s2 -> s13 -> s8 -> (silent) s1
    smp(c_Y16);  chk("w_s2", 32'(cur_state), 32'd2);
    smp(c_Y13S); chk("w_s13", 32'(cur_state), 32'd13);
    smp(c_Y18);  chk("w_s8", 32'(cur_state), 32'd8);
    smp(c_SIL);  chk("w_s1", 32'(cur_state), 32'd1);
    chk("w_viol", 32'(viol), 32'd0);
    chk("w_step", 32'(step_cnt), 32'd4);

    // Trojan path: s9 -> s17 -> s10 is not a legal successor of s17
    smp(c_S9);   chk("t_s9", 32'(cur_state), 32'd9);
    smp(c_S17);  chk("t_s17", 32'(cur_state), 32'd17);
    chk("t_noviol", 32'(viol), 32'd0);
    smp(c_S10);
    chk("t_viol", 32'(viol), 32'd1);
    chk("t_code", 32'(viol_code), 32'd2);
    chk("t_cur", 32'(cur_state), 32'd10);
    chk("t_vcnt", 32'(viol_cnt), 32'd1);

    // Back to s1 via s2, then s4 with silent samples -> {s1,s4}
    smp(c_Y16);
    smp(c_SIL);  chk("r_s1", 32'(cur_state), 32'd1);
    smp(c_S4);   chk("u_s4", 32'(cur_state), 32'd4);
    smp(c_SIL);
    smp(c_SIL);
    smp(c_SIL);
    chk("u_cand", 32'(cand), 32'h9);
    chk("u_lock", 32'(locked), 32'd0);
    chk("u_cur", 32'(cur_state), 32'd0);
    smp(c_Y5);
    chk("u_relock", 32'(cur_state), 32'd11);
    chk("u_lock2", 32'(locked), 32'd1);
    chk("u_vcnt", 32'(viol_cnt), 32'd1);

    // s11 -> s4 -> s9 -> s5, then silent from s5 has no successor
    smp(c_S4);
    smp(c_S9);
    smp(c_S5);   chk("e_s5", 32'(cur_state), 32'd5);
    chk("e_vcnt0", 32'(viol_cnt), 32'd1);
    smp(c_SIL);
    chk("e_code", 32'(viol_code), 32'd2);
    chk("e_cand", 32'(cand), 32'h1);
    chk("e_vcnt", 32'(viol_cnt), 32'd2);

    // Bad pattern opens every state, then y4 relocks on s12
    smp(c_Y1);
    chk("b_code", 32'(viol_code), 32'd1);
    chk("b_cand", 32'(cand), 32'h3FFFF);
    chk("b_cur", 32'(cur_state), 32'd0);
    chk("b_vcnt", 32'(viol_cnt), 32'd3);
    smp(c_Y4);
    chk("b_s12", 32'(cur_state), 32'd12);
    chk("b_vcnt2", 32'(viol_cnt), 32'd3);
    chk("b_code2", 32'(viol_code), 32'd1);
    chk("b_step", 32'(step_cnt), 32'd20);

    // Saturation on the 2-bit counter instance
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("s_vcnt2_0", 32'(viol_cnt2), 32'd0);
    smp(c_Y1); smp(c_Y1); smp(c_Y1);
    chk("s_vcnt2_3", 32'(viol_cnt2), 32'd3);
    smp(c_Y1); smp(c_Y1);
    chk("s_vcnt2_sat", 32'(viol_cnt2), 32'd3);
    chk("s_vcnt8", 32'(viol_cnt), 32'd5);
    chk("s_viol2", 32'(viol2), 32'd1);
    chk("s_step2", 32'(step_cnt2), 32'd5);

    // Reset wins over a simultaneous sample
    @(negedge clk);
    rst = 1'b1; sample = 1'b1; y = c_Y1;
    @(posedge clk);
    #1;
    chk_reset("rs");
    chk("rs_cand2", 32'(cand2), 32'h1);
    chk("rs_vcnt2", 32'(viol_cnt2), 32'd0);
    chk("rs_step2", 32'(step_cnt2), 32'd0);
    chk("rs_viol2", 32'(viol2), 32'd0);
    sample = 1'b0; y = '0; rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
